// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: forwarding-select encoding, FSM states,
// the in-flight write record and the youngest-producer selection helper.
package hazard_scoreboard_pkg;

   // Register numbers are carried zero-extended to this width inside the scoreboard.
   localparam int RD_MAX_W = 8;

   typedef logic [RD_MAX_W-1:0] rd_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      HALTED   = 2'd2
   } state_t;

   typedef struct packed {
      logic v;
      rd_t  rd;
      logic ld;
   } inflight_t;

   // hits[0]=EX, hits[1]=MEM, hits[2]=WB; the youngest producer holds the freshest value.
   function automatic fwd_sel_t pick_fwd(input logic [2:0] hits);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (hits[0])      sel = FWD_EX;
      else if (hits[1]) sel = FWD_MEM;
      else if (hits[2]) sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One in-flight write record {v, rd, ld} with its source-operand comparators.
module inflight_slot
   import hazard_scoreboard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      shift,
   input  inflight_t entry_next,
   input  rd_t       num_a,
   input  rd_t       num_b,
   input  logic      use_a,
   input  logic      use_b,
   output inflight_t entry,
   output logic      hit_a,
   output logic      hit_b
);

   inflight_t entry_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         entry_reg <= '0;
      end else if (shift) begin
         entry_reg <= entry_next;
      end
   end

   assign entry = entry_reg;
   assign hit_a = use_a && entry_reg.v && (entry_reg.rd == num_a);
   assign hit_b = use_b && entry_reg.v && (entry_reg.rd == num_b);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks writes in flight through EX/MEM/WB, selects EX operand forwarding and
// stalls the front end for one cycle on a load-use hazard.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [REG_W-1:0] num_Rm_in,
   input  logic [REG_W-1:0] num_Rn_in,
   input  logic [REG_W-1:0] num_Rd_in,
   input  logic [2:0]       used_in,
   input  logic             loads_in,
   input  logic             flush_in,
   input  logic             halt_in,
   output logic             update_out,
   output logic             bubble_out,
   output logic [1:0]       fwdA_sel,
   output logic [1:0]       fwdB_sel,
   output logic [CNT_W-1:0] stall_count
);

   rd_t              num_rm;
   rd_t              num_rn;
   rd_t              num_rd;
   logic             use_rm;
   logic             use_rn;
   inflight_t        ex_next;
   inflight_t        slot_d  [3];
   inflight_t        entries [3];
   logic [2:0]       hit_a;
   logic [2:0]       hit_b;
   logic             lu_hz;
   logic             shift;
   fwd_sel_t         fwd_a;
   fwd_sel_t         fwd_b;
   state_t           state_reg;
   logic [CNT_W-1:0] stall_count_reg;

   always_comb begin
      num_rm = '0;
      num_rn = '0;
      num_rd = '0;
      num_rm[REG_W-1:0] = num_Rm_in;
      num_rn[REG_W-1:0] = num_Rn_in;
      num_rd[REG_W-1:0] = num_Rd_in;
   end

   assign use_rm = valid_in & used_in[2];
   assign use_rn = valid_in & used_in[1];

   // A load in EX has no result yet; anything reading it must wait one cycle.
   assign lu_hz = entries[0].ld & (hit_a[0] | hit_b[0]);
   assign shift = !halt_in;

   always_comb begin
      ex_next = '0;
      if (!flush_in && !lu_hz) begin
         ex_next.v  = valid_in & used_in[0];
         ex_next.rd = num_rd;
         ex_next.ld = valid_in & loads_in;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign slot_d[gi] = ex_next;
         end else begin : g_tail
            assign slot_d[gi] = entries[gi-1];
         end

         inflight_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .shift      (shift),
            .entry_next (slot_d[gi]),
            .num_a      (num_rm),
            .num_b      (num_rn),
            .use_a      (use_rm),
            .use_b      (use_rn),
            .entry      (entries[gi]),
            .hit_a      (hit_a[gi]),
            .hit_b      (hit_b[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= RUN;
         stall_count_reg <= '0;
      end else begin
         // The stall cycle put a bubble in EX, so a second back-to-back stall cannot occur.
         if (state_reg == LU_STALL) begin
            assert (!lu_hz);
         end
         if (halt_in) begin
            state_reg <= HALTED;
         end else if (!flush_in && lu_hz) begin
            state_reg <= LU_STALL;
            if (stall_count_reg != {CNT_W{1'b1}}) begin
               stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
         end else begin
            state_reg <= RUN;
         end
      end
   end

   always_comb begin
      update_out = 1'b1;
      bubble_out = 1'b0;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
      if (rst) begin
         fwd_a = pick_fwd(hit_a);
         fwd_b = pick_fwd(hit_b);
         if (halt_in) begin
            update_out = 1'b0;
         end else if (flush_in) begin
            bubble_out = 1'b1;
         end else if (lu_hz) begin
            update_out = 1'b0;
            bubble_out = 1'b1;
         end else begin
            bubble_out = !valid_in;
         end
      end
   end

   assign fwdA_sel    = fwd_a;
   assign fwdB_sel    = fwd_b;
   assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a queue-based pipeline model.
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [2:0]  num_Rm_in;
   logic [2:0]  num_Rn_in;
   logic [2:0]  num_Rd_in;
   logic [2:0]  used_in;
   logic        loads_in;
   logic        flush_in;
   logic        halt_in;
   logic        update_out;
   logic        bubble_out;
   logic [1:0]  fwdA_sel;
   logic [1:0]  fwdB_sel;
   logic [15:0] stall_count;
   logic        sat_upd;
   logic        sat_bub;
   logic [1:0]  sat_fa;
   logic [1:0]  sat_fb;
   logic [1:0]  sat_cnt;

   hazard_scoreboard #(.REG_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in), .num_Rd_in(num_Rd_in),
      .used_in(used_in), .loads_in(loads_in), .flush_in(flush_in), .halt_in(halt_in),
      .update_out(update_out), .bubble_out(bubble_out),
      .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .stall_count(stall_count)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   hazard_scoreboard #(.REG_W(3), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in), .num_Rd_in(num_Rd_in),
      .used_in(used_in), .loads_in(loads_in), .flush_in(flush_in), .halt_in(halt_in),
      .update_out(sat_upd), .bubble_out(sat_bub),
      .fwdA_sel(sat_fa), .fwdB_sel(sat_fb), .stall_count(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {bit v; int rd; bit ld;} ent_t;
   ent_t pipe [3];        // [0]=EX, [1]=MEM, [2]=WB
   int   m_cnt;
   int   m_sat;
   int   errors = 0;
   int   checks = 0;
   int   step_no = 0;
   bit   last_lu;
   logic        s_upd;
   logic        s_bub;
   logic [1:0]  s_fa;
   logic [1:0]  s_fb;
   logic [15:0] s_cnt;
   logic [1:0]  s_sat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int src_sel(input bit v, input bit use_it, input int num);
      if (!v || !use_it) return 0;
      for (int i = 0; i < 3; i++) begin
         if (pipe[i].v && pipe[i].rd == num) return i + 1;
      end
      return 0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0};
      m_cnt = 0;
      m_sat = 0;
   endtask

   // Called just after a falling edge: drive, check mid-cycle, then advance the model at the rising edge.
   task automatic step(input bit v, input int rm, input int rn, input int rd,
                       input bit [2:0] used, input bit ld, input bit fl, input bit hl);
      int ea;
      int eb;
      bit lu;
      bit eu;
      bit eby;
      valid_in  = v;
      num_Rm_in = rm[2:0];
      num_Rn_in = rn[2:0];
      num_Rd_in = rd[2:0];
      used_in   = used;
      loads_in  = ld;
      flush_in  = fl;
      halt_in   = hl;
      #1;
      ea = src_sel(v, used[2], rm);
      eb = src_sel(v, used[1], rn);
      lu = pipe[0].ld && (ea == 1 || eb == 1);
      if (!rst) begin
         ea = 0; eb = 0; eu = 1; eby = 0;
      end else if (hl) begin
         eu = 0; eby = 0;
      end else if (fl) begin
         eu = 1; eby = 1;
      end else if (lu) begin
         eu = 0; eby = 1;
      end else begin
         eu = 1; eby = !v;
      end
      s_upd = update_out; s_bub = bubble_out; s_fa = fwdA_sel; s_fb = fwdB_sel;
      s_cnt = stall_count; s_sat = sat_cnt;
      chk("update_out", 32'(update_out), 32'(eu));
      chk("bubble_out", 32'(bubble_out), 32'(eby));
      chk("fwdA_sel", 32'(fwdA_sel), 32'(ea));
      chk("fwdB_sel", 32'(fwdB_sel), 32'(eb));
      chk("stall_count", 32'(stall_count), 32'(m_cnt));
      chk("sat_stall_count", 32'(sat_cnt), 32'(m_sat));
      chk("sat_update_out", 32'(sat_upd), 32'(eu));
      chk("sat_bubble_out", 32'(sat_bub), 32'(eby));
      chk("sat_fwd", 32'({sat_fa, sat_fb}), 32'({ea[1:0], eb[1:0]}));
      $display("step %0d rst=%0d v=%0d rm=%0d rn=%0d rd=%0d used=%b ld=%0d fl=%0d hl=%0d -> upd=%0d bub=%0d fA=%0d fB=%0d cnt=%0d",
               step_no, rst, v, rm, rn, rd, used, ld, fl, hl, s_upd, s_bub, s_fa, s_fb, s_cnt);
      step_no++;
      last_lu = rst && !hl && !fl && lu;
      @(posedge clk);
      if (!rst) begin
         model_clear();
      end else if (!hl) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (fl || lu) pipe[0] = '{0, 0, 0};
         else          pipe[0] = '{v && used[0], rd, ld};
         if (!fl && lu) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 3) m_sat++;
         end
      end
      @(negedge clk);
   endtask

   task automatic add(input int rd, input int rm, input int rn);
      step(1, rm, rn, rd, 3'b111, 0, 0, 0);
   endtask

   task automatic ldr(input int rd, input int rn);
      step(1, 0, rn, rd, 3'b011, 1, 0, 0);
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 3'b000, 0, 0, 0);
   endtask

   task automatic drain();
      repeat (3) nop();
   endtask

   initial begin
      int exp_gap [4] = '{1, 2, 3, 0};
      bit r_v;
      int r_rm;
      int r_rn;
      int r_rd;
      bit [2:0] r_used;
      bit r_ld;
      bit r_fl;
      bit r_hl;

      rst = 1'b0; valid_in = 0; num_Rm_in = 0; num_Rn_in = 0; num_Rd_in = 0;
      used_in = 0; loads_in = 0; flush_in = 0; halt_in = 0;
      model_clear();
      @(posedge clk);
      @(negedge clk);

      nop();
      nop();
      chk("reset_update", 32'(s_upd), 32'd1);
      chk("reset_bubble", 32'(s_bub), 32'd0);
      chk("reset_fwd", 32'({s_fa, s_fb}), 32'd0);
      chk("reset_count", 32'(s_cnt), 32'd0);
      rst = 1'b1;

      // Producer-to-consumer distance 0..3 NOPs.
      for (int g = 0; g < 4; g++) begin
         add(1, 0, 0);
         repeat (g) nop();
         add(2, 1, 3);
         chk("gap_fwdA", 32'(s_fa), 32'(exp_gap[g]));
         chk("gap_update", 32'(s_upd), 32'd1);
         drain();
      end

      ldr(4, 7);
      add(5, 4, 0);
      chk("lu_update", 32'(s_upd), 32'd0);
      chk("lu_bubble", 32'(s_bub), 32'd1);
      add(5, 4, 0);
      chk("lu_fwdA_mem", 32'(s_fa), 32'd2);
      chk("lu_count", 32'(s_cnt), 32'd1);
      chk("lu_resume", 32'(s_upd), 32'd1);
      drain();

      ldr(4, 7);
      step(1, 4, 0, 5, 3'b111, 0, 1, 0);
      chk("flush_update", 32'(s_upd), 32'd1);
      chk("flush_bubble", 32'(s_bub), 32'd1);
      nop();
      chk("flush_count", 32'(s_cnt), 32'd1);
      drain();

      add(1, 0, 0);
      repeat (3) begin
         step(1, 1, 3, 2, 3'b111, 0, 0, 1);
         chk("halt_update", 32'(s_upd), 32'd0);
         chk("halt_fwdA", 32'(s_fa), 32'd1);
      end
      add(2, 1, 3);
      chk("release_fwdA", 32'(s_fa), 32'd1);
      chk("release_update", 32'(s_upd), 32'd1);
      drain();

      repeat (4) begin
         ldr(4, 7);
         add(5, 4, 0);
         add(5, 4, 0);
      end
      chk("sat_hold", 32'(s_sat), 32'd3);
      chk("wide_count", 32'(s_cnt), 32'd5);
      drain();

      ldr(4, 7);
      add(5, 4, 0);
      rst = 1'b0;
      add(5, 4, 0);
      rst = 1'b1;
      add(5, 4, 0);
      chk("stall_reset_fwd", 32'({s_fa, s_fb}), 32'd0);
      chk("stall_reset_update", 32'(s_upd), 32'd1);
      chk("stall_reset_count", 32'(s_cnt), 32'd0);
      drain();

      // Random traffic; a stalled instruction is re-presented, as the held readreg stage would.
      r_v = 0; r_rm = 0; r_rn = 0; r_rd = 0; r_used = 0; r_ld = 0;
      for (int n = 0; n < 400; n++) begin
         if (!last_lu) begin
            r_v    = ($urandom_range(0, 99) < 85);
            r_rm   = $urandom_range(0, 3);
            r_rn   = $urandom_range(0, 3);
            r_rd   = $urandom_range(0, 3);
            r_used = 3'($urandom_range(0, 7));
            r_ld   = ($urandom_range(0, 99) < 30);
         end
         r_fl = ($urandom_range(0, 99) < 8);
         r_hl = ($urandom_range(0, 99) < 8);
         rst  = ($urandom_range(0, 49) != 0);
         step(r_v, r_rm, r_rn, r_rd, r_used, r_ld, r_fl, r_hl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
